// File: rtl/wave_playback_ctrl.sv
// Playback sequencer for a waveform sample RAM feeding the AD9744 data latch.
// It walks a programmable address window at a divided rate and delays the DAC latch enable to match the RAM read latency.
module wave_playback_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [15:0]       burst_count,
  input  logic [15:0]       clk_div,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              dac_en,
  output logic              busy,
  output logic              done
);

  localparam int DW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [ADDR_W:0] ONE_L = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [15:0]         burst_q;
  logic [15:0]         div_q;
  logic [ADDR_W:0]     idx_q;
  logic [15:0]         pass_q;
  logic [15:0]         divcnt_q;
  logic                final_q;
  logic [DW-1:0]       drain_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_en_q;
  logic [MEM_LAT-1:0]  dac_sr_q;
  logic                busy_q;
  logic                done_q;

  logic [ADDR_W:0]     idx_d;
  logic [15:0]         pass_d;
  logic                final_d;
  logic [ADDR_W-1:0]   addr_d;

  // Next-sample position; final_d marks the sample that ends the whole playback.
  always_comb begin
    idx_d   = idx_q + ONE_L;
    pass_d  = pass_q;
    if (idx_q == len_q - ONE_L) begin
      idx_d  = '0;
      pass_d = pass_q + 16'd1;
    end
    final_d = (idx_d == len_q - ONE_L) && (burst_q != 16'd0) &&
              (pass_d == burst_q - 16'd1);
    addr_d  = base_q + idx_d[ADDR_W-1:0];
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      pass_q     <= '0;
      divcnt_q   <= '0;
      final_q    <= 1'b0;
      drain_q    <= '0;
      mem_addr_q <= '0;
      mem_en_q   <= 1'b0;
      dac_sr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      mem_en_q    <= 1'b0;
      done_q      <= 1'b0;
      dac_sr_q[0] <= mem_en_q;
      for (int i = 1; i < MEM_LAT; i++) dac_sr_q[i] <= dac_sr_q[i-1];

      case (state_q)
        IDLE: begin
          if (start && (length != '0) && !stop) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            base_q     <= start_addr;
            len_q      <= length;
            burst_q    <= burst_count;
            div_q      <= clk_div;
            idx_q      <= '0;
            pass_q     <= '0;
            divcnt_q   <= clk_div;
            final_q    <= (length == ONE_L) && (burst_count == 16'd1);
            mem_addr_q <= start_addr;
            mem_en_q   <= 1'b1;
          end
        end
        RUN: begin
          // Stop wins over a sample that happens to be due on the same edge.
          if (stop || final_q) begin
            state_q <= DRAIN;
            drain_q <= DW'(MEM_LAT - 1);
          end else if (divcnt_q == 16'd0) begin
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            final_q    <= final_d;
            divcnt_q   <= div_q;
            mem_addr_q <= addr_d;
            mem_en_q   <= 1'b1;
          end else begin
            divcnt_q <= divcnt_q - 16'd1;
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_en   = mem_en_q;
  assign dac_en   = dac_sr_q[MEM_LAT-1];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_wave_playback_ctrl.sv
// Self-checking bench for wave_playback_ctrl: directed and random playbacks compared cycle by cycle
// against a timing model derived from the sample period, pass count and stop/reset edges.
module tb_wave_playback_ctrl;
  localparam int AW = 12;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, stop;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic [15:0]   burst_count, clk_div;
  logic [AW-1:0] mem_addr;
  logic          mem_en, dac_en, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state for the current playback: edge 0 is the accepting start edge, m_d the edge leaving RUN.
  int m_sa, m_len, m_div, m_d;

  wave_playback_ctrl #(.ADDR_W(AW), .MEM_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .start_addr(start_addr), .length(length), .burst_count(burst_count),
    .clk_div(clk_div), .mem_addr(mem_addr), .mem_en(mem_en),
    .dac_en(dac_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic bit exp_en(int e);
    return (e >= 0) && (e < m_d) && ((e % (m_div + 1)) == 0);
  endfunction

  function automatic int exp_addr(int e);
    return (m_sa + (e / (m_div + 1)) % m_len) % (1 << AW);
  endfunction

  task automatic chk(string tag, int e, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  task automatic check_edge(string tag, int e);
    chk({tag, ".mem_en"}, e, 32'(mem_en), 32'(exp_en(e)));
    if (exp_en(e)) chk({tag, ".mem_addr"}, e, 32'(mem_addr), 32'(exp_addr(e)));
    chk({tag, ".dac_en"}, e, 32'(dac_en), 32'(exp_en(e - ML)));
    chk({tag, ".busy"},   e, 32'(busy),   32'(e < m_d + ML));
    chk({tag, ".done"},   e, 32'(done),   32'(e == m_d + ML));
  endtask

  task automatic check_zero(string tag, int e);
    chk({tag, ".mem_en"},   e, 32'(mem_en),   32'd0);
    chk({tag, ".mem_addr"}, e, 32'(mem_addr), 32'd0);
    chk({tag, ".dac_en"},   e, 32'(dac_en),   32'd0);
    chk({tag, ".busy"},     e, 32'(busy),     32'd0);
    chk({tag, ".done"},     e, 32'(done),     32'd0);
  endtask

  // One playback; config inputs and start are scrambled while busy to prove they are latched.
  task automatic play(string tag, int sa, int len, int burst, int div, int stop_at, int rst_at);
    int dn;
    m_sa  = sa;
    m_len = len;
    m_div = div;
    dn    = (burst == 0) ? (1 << 30) : ((len * burst - 1) * (div + 1) + 1);
    m_d   = (stop_at > 0 && stop_at < dn) ? stop_at : dn;
    @(negedge clk);
    start       = 1'b1;
    stop        = 1'b0;
    start_addr  = AW'(sa);
    length      = (AW+1)'(len);
    burst_count = 16'(burst);
    clk_div     = 16'(div);
    @(posedge clk); #1;
    check_edge(tag, 0);
    for (int e = 1; e <= m_d + ML + 3; e++) begin
      @(negedge clk);
      if (e <= m_d + ML) begin
        start       = 1'($urandom);
        start_addr  = AW'($urandom);
        length      = (AW+1)'($urandom);
        burst_count = 16'($urandom);
        clk_div     = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      stop = (e == stop_at);
      if (e == rst_at) rst_n = 1'b0;
      @(posedge clk); #1;
      if (e == rst_at) begin
        check_zero({tag, ".rst"}, e);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check_zero({tag, ".rst_hold"}, e + 1);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      check_edge(tag, e);
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Start requests that must be ignored in IDLE.
  task automatic idle_check(string tag, int len, bit stp);
    @(negedge clk);
    start  = 1'b1;
    stop   = stp;
    length = (AW+1)'(len);
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      chk({tag, ".mem_en"}, e, 32'(mem_en), 32'd0);
      chk({tag, ".dac_en"}, e, 32'(dac_en), 32'd0);
      chk({tag, ".busy"},   e, 32'(busy),   32'd0);
      chk({tag, ".done"},   e, 32'(done),   32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int sa, len, burst, div, stop_at, dn;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    start_addr = '0; length = '0; burst_count = '0; clk_div = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset", 0);
    @(negedge clk);
    rst_n = 1'b1;

    play("t1_basic",    10,   4, 1, 0, -1, -1);
    play("t2_div",      0,    3, 1, 2, -1, -1);
    play("t3_wrap",     4094, 4, 1, 0, -1, -1);
    play("t4_burst3",   0,    2, 3, 0, -1, -1);
    play("t4_cont",     0,    2, 0, 0, 203, -1);
    play("t5_stop",     20,   8, 1, 0, 3, -1);
    play("t5_stopdue",  7,    5, 2, 2, 6, -1);
    idle_check("t5_len0", 0, 1'b0);
    idle_check("t5_stopstart", 4, 1'b1);
    play("t6_rst",      100,  8, 2, 1, -1, 5);
    play("t6_fresh",    100,  8, 1, 1, -1, -1);
    play("len1",        4095, 1, 1, 3, -1, -1);

    for (int i = 0; i < 12; i++) begin
      sa    = ($urandom % 2 != 0) ? 4090 + int'($urandom % 6) : int'($urandom % 4096);
      len   = 1 + int'($urandom % 6);
      burst = int'($urandom % 4);
      div   = int'($urandom % 4);
      dn    = (burst == 0) ? 60 : (len * burst - 1) * (div + 1) + 1;
      stop_at = (burst == 0 || ($urandom % 3) == 0) ? 1 + int'($urandom % dn) : -1;
      play("rand", sa, len, burst, div, stop_at, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
